// File: rtl/csel_pkg.sv
// Shared defaults and parameter legality checks for the pipelined carry-select adder.
package csel_pkg;

  localparam int CSEL_WIDTH_DEF  = 16;
  localparam int CSEL_BLOCK_DEF  = 4;
  localparam int CSEL_STAGES_DEF = 2;

  function automatic bit csel_width_ok(input int width);
    return (width >= 4) && (width <= 64);
  endfunction

  function automatic bit csel_block_ok(input int width, input int block);
    return (block >= 1) && (block <= width) && ((width % block) == 0);
  endfunction

  function automatic bit csel_stages_ok(input int width, input int block, input int stages);
    int nb;
    nb = width / block;
    return (stages >= 1) && (stages <= nb) && ((nb % stages) == 0);
  endfunction

  function automatic bit csel_params_ok(input int width, input int block, input int stages);
    if (!csel_width_ok(width)) return 1'b0;
    if (!csel_block_ok(width, block)) return 1'b0;
    return csel_stages_ok(width, block, stages);
  endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select block: both carry-in hypotheses are summed in parallel and
// the incoming carry picks the result.
module csel_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK:0] res_c0;
  logic [BLOCK:0] res_c1;

  assign res_c0 = {1'b0, a} + {1'b0, b};
  assign res_c1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

  assign {cout, sum} = cin ? res_c1 : res_c0;

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder with valid/ready handshake.
// Optional signed-overflow output enabled by defining CSEL_ADDER_OVERFLOW_EN.
import csel_pkg::*;

module csel_adder_pipe #(
  parameter int WIDTH  = CSEL_WIDTH_DEF,
  parameter int BLOCK  = CSEL_BLOCK_DEF,
  parameter int STAGES = CSEL_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CSEL_ADDER_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NB  = WIDTH / BLOCK;
  localparam int BPS = NB / STAGES;

  if (!csel_params_ok(WIDTH, BLOCK, STAGES)) begin : g_illegal
    $error("csel_adder_pipe: illegal WIDTH/BLOCK/STAGES combination");
  end

  logic adv;

  // Whole pipeline moves as one unit: either every stage loads or all hold.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, sum_in, sum_next;
    logic             cy_in, vld_in;
    logic [BPS:0]     cy_chain;
    logic [BLOCK-1:0] blk_sum [BPS];

    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             cy_reg, vld_reg;

    if (gi == 0) begin : g_head
      assign a_in   = a;
      assign b_in   = b;
      assign sum_in = '0;
      assign cy_in  = cin;
      assign vld_in = in_valid;
    end else begin : g_body
      assign a_in   = g_stage[gi-1].a_reg;
      assign b_in   = g_stage[gi-1].b_reg;
      assign sum_in = g_stage[gi-1].sum_reg;
      assign cy_in  = g_stage[gi-1].cy_reg;
      assign vld_in = g_stage[gi-1].vld_reg;
    end

    assign cy_chain[0] = cy_in;

    for (genvar gj = 0; gj < BPS; gj++) begin : g_blk
      localparam int LO = (gi * BPS + gj) * BLOCK;
      csel_block #(.BLOCK(BLOCK)) u_blk (
        .a    (a_in[LO +: BLOCK]),
        .b    (b_in[LO +: BLOCK]),
        .cin  (cy_chain[gj]),
        .sum  (blk_sum[gj]),
        .cout (cy_chain[gj+1])
      );
    end

    always_comb begin
      sum_next = sum_in;
      for (int k = 0; k < BPS; k++) begin
        sum_next[(gi * BPS + k) * BLOCK +: BLOCK] = blk_sum[k];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        a_reg   <= '0;
        b_reg   <= '0;
        sum_reg <= '0;
        cy_reg  <= 1'b0;
        vld_reg <= 1'b0;
      end else if (adv) begin
        a_reg   <= a_in;
        b_reg   <= b_in;
        sum_reg <= sum_next;
        cy_reg  <= cy_chain[BPS];
        vld_reg <= vld_in;
      end
    end

    // Operand bits already consumed ride along unchanged; synthesis trims them.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{a_reg, b_reg};
  end

  assign out_valid = g_stage[STAGES-1].vld_reg;
  assign sum       = g_stage[STAGES-1].sum_reg;
  assign cout      = g_stage[STAGES-1].cy_reg;

`ifdef CSEL_ADDER_OVERFLOW_EN
  // Carry into the MSB is recovered from sum^a^b at the top bit.
  assign ovf = cout ^ sum[WIDTH-1]
             ^ g_stage[STAGES-1].a_reg[WIDTH-1]
             ^ g_stage[STAGES-1].b_reg[WIDTH-1];
`endif

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed self-checking bench for csel_adder_pipe (8-bit/2-stage and 16-bit/4-stage).
// Overflow checks are compiled in when CSEL_ADDER_OVERFLOW_EN is defined.
module tb_csel_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16;
  logic [15:0] a16, b16, sum16;
`ifdef CSEL_ADDER_OVERFLOW_EN
  logic        ovf8, ovf16;
`endif

  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(8), .BLOCK(4), .STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8),
`ifdef CSEL_ADDER_OVERFLOW_EN
    .ovf(ovf8),
`endif
    .cout(cout8)
  );

  csel_adder_pipe #(.WIDTH(16), .BLOCK(4), .STAGES(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16),
`ifdef CSEL_ADDER_OVERFLOW_EN
    .ovf(ovf16),
`endif
    .cout(cout16)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive8(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    in_valid8 = v;
    a8 = av;
    b8 = bv;
    cin8 = cv;
  endtask

  task automatic expect8(input string tag, input logic [7:0] s, input logic c);
    check({tag, "_valid"}, 64'(out_valid8), 64'(1));
    check({tag, "_sum"}, 64'(sum8), 64'(s));
    check({tag, "_cout"}, 64'(cout8), 64'(c));
    $display("txn %s: sum=%0d cout=%0d", tag, sum8, cout8);
  endtask

  logic [7:0] sv_a [4] = '{8'h0F, 8'hF0, 8'h80, 8'h12};
  logic [7:0] sv_b [4] = '{8'h00, 8'h10, 8'h80, 8'h34};
  logic       sv_c [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] sv_s [4] = '{8'h10, 8'h00, 8'h01, 8'h46};
  logic       sv_o [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    drive8(1'b0, 8'd0, 8'd0, 1'b0);
    out_ready8 = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
    tick;
    tick;
    check("rst_valid8", 64'(out_valid8), 64'(0));
    check("rst_sum8", 64'(sum8), 64'(0));
    check("rst_cout8", 64'(cout8), 64'(0));
    check("rst_ready8", 64'(in_ready8), 64'(1));
    check("rst_valid16", 64'(out_valid16), 64'(0));
`ifdef CSEL_ADDER_OVERFLOW_EN
    check("rst_ovf8", 64'(ovf8), 64'(0));
`endif
    rst = 1'b0;

    // 199 + 55 = 254, two-cycle latency
    drive8(1'b1, 8'd199, 8'd55, 1'b0);
    tick;
    drive8(1'b0, 8'd0, 8'd0, 1'b0);
    check("lat_mid_valid", 64'(out_valid8), 64'(0));
    tick;
    expect8("add_199_55", 8'd254, 1'b0);
    tick;
    check("after_bubble", 64'(out_valid8), 64'(0));

    // back-to-back: 199+56+1 wraps, then 100+1
    drive8(1'b1, 8'd199, 8'd56, 1'b1);
    tick;
    drive8(1'b1, 8'd100, 8'd1, 1'b0);
    tick;
    drive8(1'b0, 8'd0, 8'd0, 1'b0);
    expect8("wrap_199_56_1", 8'd0, 1'b1);
    tick;
    expect8("add_100_1", 8'd101, 1'b0);
    tick;
    check("b2b_drain", 64'(out_valid8), 64'(0));

    // full-throughput stream with block-boundary carries
    for (int i = 0; i < 4; i++) begin
      drive8(1'b1, sv_a[i], sv_b[i], sv_c[i]);
      tick;
      if (i > 0) expect8($sformatf("stream%0d", i - 1), sv_s[i-1], sv_o[i-1]);
    end
    drive8(1'b0, 8'd0, 8'd0, 1'b0);
    tick;
    expect8("stream3", sv_s[3], sv_o[3]);
    tick;

    // 16-bit, 4 stages: all-ones + 1, then cin carry across a stage
    in_valid16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0;
    tick;
    check("w16_lat1", 64'(out_valid16), 64'(0));
    a16 = 16'h00FF; b16 = 16'h0000; cin16 = 1'b1;
    tick;
    in_valid16 = 1'b0;
    check("w16_lat2", 64'(out_valid16), 64'(0));
    tick;
    check("w16_lat3", 64'(out_valid16), 64'(0));
    tick;
    check("w16_ffff_valid", 64'(out_valid16), 64'(1));
    check("w16_ffff_sum", 64'(sum16), 64'(16'h0000));
    check("w16_ffff_cout", 64'(cout16), 64'(1));
    $display("txn w16_ffff_1: sum=%0h cout=%0d", sum16, cout16);
    tick;
    check("w16_00ff_valid", 64'(out_valid16), 64'(1));
    check("w16_00ff_sum", 64'(sum16), 64'(16'h0100));
    check("w16_00ff_cout", 64'(cout16), 64'(0));
    $display("txn w16_00ff_cin: sum=%0h cout=%0d", sum16, cout16);
    tick;
    check("w16_drain", 64'(out_valid16), 64'(0));

    // backpressure: two in the pipe, a third waiting at the input
    drive8(1'b1, 8'd5, 8'd89, 1'b1);
    tick;
    drive8(1'b1, 8'd10, 8'd20, 1'b0);
    tick;
    out_ready8 = 1'b0;
    drive8(1'b1, 8'd200, 8'd100, 1'b0);
    #1;
    check("stall_ready0", 64'(in_ready8), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("stall%0d_valid", i), 64'(out_valid8), 64'(1));
      check($sformatf("stall%0d_sum", i), 64'(sum8), 64'(95));
      check($sformatf("stall%0d_ready", i), 64'(in_ready8), 64'(0));
    end
    out_ready8 = 1'b1;
    #1;
    check("release_ready", 64'(in_ready8), 64'(1));
    expect8("held_5_89_1", 8'd95, 1'b0);
    tick;
    drive8(1'b0, 8'd0, 8'd0, 1'b0);
    expect8("after_10_20", 8'd30, 1'b0);
    tick;
    expect8("after_200_100", 8'd44, 1'b1);
    tick;
    check("stall_drain", 64'(out_valid8), 64'(0));

    // reset with two results in flight plus an input in the reset cycle
    drive8(1'b1, 8'd1, 8'd2, 1'b0);
    tick;
    drive8(1'b1, 8'd3, 8'd4, 1'b0);
    tick;
    rst = 1'b1;
    drive8(1'b1, 8'd50, 8'd60, 1'b0);
    #1;
    check("rst_cycle_ready", 64'(in_ready8), 64'(1));
    tick;
    rst = 1'b0;
    drive8(1'b0, 8'd0, 8'd0, 1'b0);
    check("flush_sum", 64'(sum8), 64'(0));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("flush%0d_valid", i), 64'(out_valid8), 64'(0));
      tick;
    end

`ifdef CSEL_ADDER_OVERFLOW_EN
    drive8(1'b1, 8'h7F, 8'h01, 1'b0);
    tick;
    drive8(1'b1, 8'hFF, 8'h01, 1'b0);
    tick;
    drive8(1'b0, 8'd0, 8'd0, 1'b0);
    expect8("ovf_7f_01", 8'h80, 1'b0);
    check("ovf_7f_01_ovf", 64'(ovf8), 64'(1));
    tick;
    expect8("ovf_ff_01", 8'h00, 1'b1);
    check("ovf_ff_01_ovf", 64'(ovf8), 64'(0));
    tick;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
